sent_tx_frame_gen: RTL and testbench



---
 rtl/sent_pkg.sv | 33 +++
 rtl/sent_tx_frame_gen_if.sv | 28 ++
 rtl/sent_crc4.sv | 28 ++
 rtl/sent_tx_frame_gen.sv | 197 +++++++++++++++++++
 tb/tb_sent_tx_frame_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sent_pkg.sv
// Shared types, symbol lengths and the CRC-4 step used by the SENT frame generator.
package sent_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CRC,
    ST_PAUSE
  } sent_state_e;

  localparam int SYNC_TICKS  = 56;
  localparam int NIBBLE_BASE = 12;
  localparam int MIN_PAUSE   = 12;

  localparam logic [3:0] CRC_SEED = 4'b0101;
  localparam logic [3:0] CRC_POLY = 4'b1101;

  // One nibble through the CRC register, MSB first.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ nib[i];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sent_tx_frame_gen_if.sv
// Frame hand-off between the APB-side FIFO/register logic and the SENT transmitter.
interface sent_tx_frame_gen_if #(
  parameter int MAX_NIBBLES = 6,
  parameter int DIV_WIDTH   = 8,
  parameter int PAUSE_WIDTH = 12
);
  logic [DIV_WIDTH-1:0]     tick_div;
  logic [3:0]               num_nibbles;
  logic                     crc_mode;
  logic                     pause_en;
  logic [PAUSE_WIDTH-1:0]   pause_ticks;
  logic [3:0]               status_nibble;
  logic [4*MAX_NIBBLES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_ready;

  modport master (
    output tick_div, num_nibbles, crc_mode, pause_en, pause_ticks,
           status_nibble, frame_data, frame_valid,
    input  frame_ready
  );

  modport slave (
    input  tick_div, num_nibbles, crc_mode, pause_en, pause_ticks,
           status_nibble, frame_data, frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/sent_crc4.sv
// Serial CRC-4 engine: reseeds on start, absorbs one nibble per clock while nibble_valid.
module sent_crc4
  import sent_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       nibble_valid,
  input  logic [3:0] nibble,
  output logic [3:0] crc
);

  logic [3:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (start)             crc_d = CRC_SEED;
    else if (nibble_valid) crc_d = crc4_step(crc_q, nibble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC_SEED;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SAE J2716 SENT frame transmitter: sync, status, 1..MAX_NIBBLES data, CRC and optional pause.
module sent_tx_frame_gen
  import sent_pkg::*;
#(
  parameter int MAX_NIBBLES = 6,
  parameter int DIV_WIDTH   = 8,
  parameter int LOW_TICKS   = 5,
  parameter int PAUSE_WIDTH = 12
) (
  input  logic                clk_tx,
  input  logic                reset_tx,
  sent_tx_frame_gen_if.slave  frm,
  output logic                sent_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int PAUSE_MAX = (1 << PAUSE_WIDTH) - 1;
  localparam int TICK_MAX  = (SYNC_TICKS > PAUSE_MAX) ? SYNC_TICKS : PAUSE_MAX;
  localparam int TICK_W    = $clog2(TICK_MAX + 1);
  localparam int DATA_W    = 4 * MAX_NIBBLES;

  sent_state_e            state_q, state_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d, div_q, div_d;
  logic [3:0]             n_q, n_d, status_q, status_d;
  logic [3:0]             nib_idx_q, nib_idx_d, feed_idx_q, feed_idx_d;
  logic                   aug_q, aug_d, pause_en_q, pause_en_d, tail_q, tail_d;
  logic [PAUSE_WIDTH-1:0] pause_q, pause_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   sent_out_q, sent_out_d, busy_q, busy_d;
  logic                   done_q, done_d, ready_q, ready_d;

  logic                   accept, tick_en, crc_start, crc_valid;
  logic [3:0]             crc_nib, crc_val, cur_nib, feed_total;
  logic [TICK_W-1:0]      sym_len, last_tick;

  function automatic logic [3:0] pick_nibble(input logic [DATA_W-1:0] d, input logic [3:0] idx);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < MAX_NIBBLES; i++)
      if (idx == 4'(i)) r = d[4*i +: 4];
    return r;
  endfunction

  assign accept     = frm.frame_valid && ready_q;
  assign tick_en    = (presc_q == div_q);
  assign feed_total = n_q + {3'b000, aug_q};
  assign crc_valid  = (state_q == ST_SYNC) && (feed_idx_q < feed_total);
  assign crc_nib    = (feed_idx_q < n_q) ? pick_nibble(data_q, feed_idx_q) : 4'h0;
  assign last_tick  = sym_len - TICK_W'(1);

  sent_crc4 u_crc (
    .clk          (clk_tx),
    .rst          (reset_tx),
    .start        (crc_start),
    .nibble_valid (crc_valid),
    .nibble       (crc_nib),
    .crc          (crc_val)
  );

  always_comb begin
    cur_nib = 4'h0;
    sym_len = TICK_W'(SYNC_TICKS);
    case (state_q)
      ST_STATUS: cur_nib = status_q;
      ST_DATA:   cur_nib = pick_nibble(data_q, nib_idx_q);
      ST_CRC:    cur_nib = crc_val;
      default:   cur_nib = 4'h0;
    endcase
    case (state_q)
      ST_STATUS, ST_DATA, ST_CRC: sym_len = TICK_W'(NIBBLE_BASE) + TICK_W'(cur_nib);
      ST_PAUSE: sym_len = (pause_q < PAUSE_WIDTH'(MIN_PAUSE)) ? TICK_W'(MIN_PAUSE)
                                                              : TICK_W'(pause_q);
      default:  sym_len = TICK_W'(SYNC_TICKS);
    endcase
  end

  // The final symbol gets one extra "tail" clock so frame_done and busy line up with the
  // end of the last symbol on sent_out, which trails the FSM by one register stage.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    presc_d    = tick_en ? '0 : presc_q + 1'b1;
    div_d      = div_q;
    n_d        = n_q;
    aug_d      = aug_q;
    pause_en_d = pause_en_q;
    pause_d    = pause_q;
    status_d   = status_q;
    data_d     = data_q;
    nib_idx_d  = nib_idx_q;
    feed_idx_d = crc_valid ? feed_idx_q + 4'd1 : feed_idx_q;
    tail_d     = tail_q;
    done_d     = 1'b0;
    crc_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SYNC;
          tick_cnt_d = '0;
          presc_d    = '0;
          div_d      = frm.tick_div;
          aug_d      = frm.crc_mode;
          pause_en_d = frm.pause_en;
          pause_d    = frm.pause_ticks;
          status_d   = frm.status_nibble;
          data_d     = frm.frame_data;
          nib_idx_d  = 4'd0;
          feed_idx_d = 4'd0;
          tail_d     = 1'b0;
          crc_start  = 1'b1;
          if (frm.num_nibbles == 4'd0)                      n_d = 4'd1;
          else if (frm.num_nibbles > 4'(MAX_NIBBLES))       n_d = 4'(MAX_NIBBLES);
          else                                              n_d = frm.num_nibbles;
        end
      end
      default: begin
        if (tail_q) begin
          state_d = ST_IDLE;
          tail_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tick_en) begin
          if (tick_cnt_q == last_tick) begin
            tick_cnt_d = '0;
            case (state_q)
              ST_SYNC:   state_d = ST_STATUS;
              ST_STATUS: state_d = ST_DATA;
              ST_DATA: begin
                if (nib_idx_q == n_q - 4'd1) state_d = ST_CRC;
                else nib_idx_d = nib_idx_q + 4'd1;
              end
              ST_CRC: begin
                if (pause_en_q) state_d = ST_PAUSE;
                else            tail_d  = 1'b1;
              end
              default: tail_d = 1'b1;
            endcase
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
    endcase

    sent_out_d = !((state_q != ST_IDLE) && !tail_q && (tick_cnt_q < TICK_W'(LOW_TICKS)));
    ready_d    = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      presc_q    <= '0;
      div_q      <= '0;
      n_q        <= 4'd1;
      aug_q      <= 1'b0;
      pause_en_q <= 1'b0;
      pause_q    <= '0;
      status_q   <= 4'h0;
      data_q     <= '0;
      nib_idx_q  <= 4'd0;
      feed_idx_q <= 4'd0;
      tail_q     <= 1'b0;
      sent_out_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      n_q        <= n_d;
      aug_q      <= aug_d;
      pause_en_q <= pause_en_d;
      pause_q    <= pause_d;
      status_q   <= status_d;
      data_q     <= data_d;
      nib_idx_q  <= nib_idx_d;
      feed_idx_q <= feed_idx_d;
      tail_q     <= tail_d;
      sent_out_q <= sent_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign sent_out        = sent_out_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign frm.frame_ready = ready_q;

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Bench for sent_tx_frame_gen: table of frames, symbol-period scoreboard, back-to-back and reset cases.
module tb_sent_tx_frame_gen;

  localparam int MAX_NIBBLES = 6;
  localparam int DIV_WIDTH   = 8;
  localparam int LOW_TICKS   = 5;
  localparam int PAUSE_WIDTH = 12;

  logic clk_tx   = 1'b0;
  logic reset_tx = 1'b1;
  logic sent_out, busy, frame_done;

  sent_tx_frame_gen_if #(
    .MAX_NIBBLES (MAX_NIBBLES),
    .DIV_WIDTH   (DIV_WIDTH),
    .PAUSE_WIDTH (PAUSE_WIDTH)
  ) frm ();

  sent_tx_frame_gen #(
    .MAX_NIBBLES (MAX_NIBBLES),
    .DIV_WIDTH   (DIV_WIDTH),
    .LOW_TICKS   (LOW_TICKS),
    .PAUSE_WIDTH (PAUSE_WIDTH)
  ) dut (
    .clk_tx     (clk_tx),
    .reset_tx   (reset_tx),
    .frm        (frm),
    .sent_out   (sent_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_tx = ~clk_tx;

  typedef struct {
    logic [7:0]  div;
    logic [3:0]  nn;
    logic        crc_mode;
    logic        pause_en;
    logic [11:0] pause_ticks;
    logic [3:0]  status;
    logic [23:0] data;
    int          exp_crc;
    int          exp_total;
  } vec_t;

  typedef struct {
    int period;
    int low;
  } sym_exp_t;

  sym_exp_t sym_q[$];
  int       tot_q[$];
  vec_t     vecs[6];

  int n_checks = 0;
  int n_pass   = 0;
  int last_gap = -1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int model_crc(input logic [23:0] data, input int n, input bit aug);
    logic [3:0]  c;
    logic [3:0]  nib;
    logic [23:0] sh;
    logic        fb;
    c = 4'b0101;
    for (int i = 0; i < n + int'(aug); i++) begin
      sh  = data >> (4 * i);
      nib = (i < n) ? sh[3:0] : 4'h0;
      for (int b = 3; b >= 0; b--) begin
        fb = c[3] ^ nib[b];
        c  = {c[2:0], 1'b0};
        if (fb) c = c ^ 4'b1101;
      end
    end
    return int'(c);
  endfunction

  task automatic push_expect(input vec_t v);
    int          n, scale, crc, total;
    logic [23:0] sh;
    sym_exp_t    s;
    n     = (v.nn == 4'd0) ? 1 : ((int'(v.nn) > MAX_NIBBLES) ? MAX_NIBBLES : int'(v.nn));
    scale = int'(v.div) + 1;
    crc   = (v.exp_crc >= 0) ? v.exp_crc : model_crc(v.data, n, v.crc_mode);
    s.low = LOW_TICKS * scale;
    total = 0;
    s.period = 56 * scale;                     sym_q.push_back(s); total += s.period;
    s.period = (12 + int'(v.status)) * scale;  sym_q.push_back(s); total += s.period;
    for (int i = 0; i < n; i++) begin
      sh = v.data >> (4 * i);
      s.period = (12 + int'(sh[3:0])) * scale; sym_q.push_back(s); total += s.period;
    end
    s.period = (12 + crc) * scale;             sym_q.push_back(s); total += s.period;
    if (v.pause_en) begin
      s.period = ((int'(v.pause_ticks) < 12) ? 12 : int'(v.pause_ticks)) * scale;
      sym_q.push_back(s); total += s.period;
    end
    tot_q.push_back((v.exp_total >= 0) ? v.exp_total : total);
  endtask

  task automatic close_symbol(input int period, input int low);
    sym_exp_t s;
    if (sym_q.size() == 0) begin
      check_output("sym_underflow", 1, 0);
    end else begin
      s = sym_q.pop_front();
      check_output("sym_period", period, s.period);
      check_output("sym_low", low, s.low);
    end
  endtask

  // Line monitor: measures each symbol falling edge to falling edge and closes the frame on frame_done.
  initial begin : monitor
    logic prev_out;
    int   sym_cnt, low_cnt, sample_idx, frame_start, gap_cnt, ready_viol, busy_viol;
    bit   in_sym, in_frame, gap_run;
    prev_out = 1'b1; in_sym = 0; in_frame = 0; gap_run = 0;
    sym_cnt = 0; low_cnt = 0; sample_idx = 0; frame_start = 0; gap_cnt = 0;
    ready_viol = 0; busy_viol = 0;
    forever begin
      @(negedge clk_tx);
      if (reset_tx) begin
        in_sym = 0; in_frame = 0; gap_run = 0; prev_out = 1'b1;
      end else begin
        sample_idx++;
        if (prev_out && !sent_out) begin
          if (in_sym) close_symbol(sym_cnt, low_cnt);
          if (gap_run) begin last_gap = gap_cnt; gap_run = 0; end
          if (!in_frame) begin
            in_frame = 1; frame_start = sample_idx; ready_viol = 0; busy_viol = 0;
          end
          in_sym = 1; sym_cnt = 1; low_cnt = 1;
        end else if (frame_done) begin
          if (!in_frame) begin
            check_output("spurious_done", 1, 0);
          end else begin
            if (in_sym) close_symbol(sym_cnt, low_cnt);
            if (tot_q.size() == 0) check_output("total_underflow", 1, 0);
            else check_output("frame_total", sample_idx - frame_start, tot_q.pop_front());
            check_output("busy_at_done", int'(busy), 0);
            check_output("ready_low_in_frame", ready_viol, 0);
            check_output("busy_high_in_frame", busy_viol, 0);
          end
          in_sym = 0; in_frame = 0; gap_run = 1; gap_cnt = 0;
        end else begin
          if (in_sym) begin
            sym_cnt++;
            if (!sent_out) low_cnt++;
          end
          if (in_frame && frm.frame_ready) ready_viol++;
          if (in_frame && !busy) busy_viol++;
          if (gap_run) gap_cnt++;
        end
        prev_out = sent_out;
      end
    end
  end

  task automatic drive_fields(input vec_t v);
    frm.tick_div      = v.div;
    frm.num_nibbles   = v.nn;
    frm.crc_mode      = v.crc_mode;
    frm.pause_en      = v.pause_en;
    frm.pause_ticks   = v.pause_ticks;
    frm.status_nibble = v.status;
    frm.frame_data    = v.data;
  endtask

  task automatic apply_stimulus(input vec_t v, input bit hold_valid);
    int t;
    @(negedge clk_tx);
    drive_fields(v);
    frm.frame_valid = 1'b1;
    push_expect(v);
    t = 0;
    while (!frm.frame_ready && t < 1000) begin
      @(negedge clk_tx);
      t++;
    end
    if (t >= 1000) begin
      check_output("accept_timeout", 0, 1);
      frm.frame_valid = 1'b0;
      return;
    end
    @(posedge clk_tx);
    #1;
    if (!hold_valid) begin
      frm.frame_valid   = 1'b0;
      frm.tick_div      = 8'($urandom);
      frm.num_nibbles   = 4'($urandom);
      frm.crc_mode      = 1'($urandom);
      frm.pause_en      = 1'($urandom);
      frm.pause_ticks   = 12'($urandom);
      frm.status_nibble = 4'($urandom);
      frm.frame_data    = 24'($urandom);
    end
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (t < budget) begin
      @(negedge clk_tx);
      if (frame_done) break;
      t++;
    end
    if (t >= budget) check_output("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    vec_t rv;
    //           div    nn     crc   pen   pause    st     data          crc  total
    vecs[0] = '{8'd0, 4'd1, 1'b0, 1'b0, 12'd0,   4'h0, 24'h000000,   3,   95};
    vecs[1] = '{8'd0, 4'd1, 1'b1, 1'b0, 12'd0,   4'h0, 24'h000000,  10,  102};
    vecs[2] = '{8'd3, 4'd6, 1'b0, 1'b1, 12'd5,   4'h5, 24'h654321,   8,  792};
    vecs[3] = '{8'd1, 4'd0, 1'b0, 1'b0, 12'd0,   4'hA, 24'hFFFFF7,  -1,   -1};
    vecs[4] = '{8'd0, 4'd9, 1'b1, 1'b1, 12'd20,  4'h3, 24'hFEDCBA,  -1,   -1};
    vecs[5] = '{8'd2, 4'd3, 1'b1, 1'b1, 12'd12,  4'hF, 24'h0009A5,  -1,   -1};

    frm.frame_valid = 1'b0;
    drive_fields(vecs[0]);
    reset_tx = 1'b1;
    repeat (3) @(negedge clk_tx);
    check_output("reset_sent_out", int'(sent_out), 1);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_frame_done", int'(frame_done), 0);
    check_output("reset_frame_ready", int'(frm.frame_ready), 0);
    reset_tx = 1'b0;
    @(negedge clk_tx);
    check_output("ready_after_reset", int'(frm.frame_ready), 1);
    check_output("idle_sent_out", int'(sent_out), 1);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] frame vector %0d", i);
      apply_stimulus(vecs[i], 1'b0);
      wait_done(20000);
      check_output("sym_leftover", sym_q.size(), 0);
      repeat (3) @(negedge clk_tx);
    end

    $display("[TB] back-to-back frames with frame_valid held high");
    last_gap = -1;
    apply_stimulus(vecs[0], 1'b1);
    push_expect(vecs[0]);
    wait_done(2000);
    wait_done(2000);
    frm.frame_valid = 1'b0;
    check_output("b2b_idle_gap", last_gap, 1);
    check_output("b2b_sym_leftover", sym_q.size(), 0);
    repeat (4) @(negedge clk_tx);
    check_output("b2b_no_third_frame", int'(busy), 0);

    $display("[TB] reset during DATA");
    rv = '{8'd0, 4'd6, 1'b0, 1'b0, 12'd0, 4'h0, 24'h123456, -1, -1};
    apply_stimulus(rv, 1'b0);
    repeat (70) @(negedge clk_tx);
    check_output("pre_reset_line_low", int'(sent_out), 0);
    check_output("pre_reset_busy", int'(busy), 1);
    #2;
    reset_tx = 1'b1;
    #1;
    check_output("async_reset_sent_out", int'(sent_out), 1);
    check_output("async_reset_busy", int'(busy), 0);
    sym_q.delete();
    tot_q.delete();
    repeat (3) @(negedge clk_tx);
    reset_tx = 1'b0;
    apply_stimulus(rv, 1'b0);
    wait_done(5000);
    check_output("post_reset_sym_leftover", sym_q.size(), 0);
    repeat (3) @(negedge clk_tx);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
